// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the instruction cache.
//   icachef_t      : fetch address view {tag, idx, bytoff} for the default 16-set cache
//   icache_frame_t : one cache frame {valid, tag, data}
//   icache_state_t : cache controller states
package cpu_types_pkg;

  localparam int unsigned ICACHE_SETS  = 16;
  localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int unsigned ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Frame storage for the direct-mapped instruction cache.
// Valid bits clear asynchronously on reset; tag and data carry no reset.
// Ports:
//   CLK, nRST             : clock, async active-low reset
//   rd_idx_i              : combinational read index
//   rd_valid_o/tag_o/data_o : frame contents at rd_idx_i
//   wr_en_i, wr_idx_i     : synchronous write strobe and index
//   wr_tag_i, wr_data_i   : tag and data written (valid is set on write)
module icache_frame_array #(
  parameter int unsigned NUM_SETS = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned TAG_W    = 26,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [DATA_W-1:0]   data_q [NUM_SETS];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache between the fetch port and the
// memory controller. Hits return in the same cycle; a miss performs a
// single-word refill and the hit then appears through the normal hit path.
// Optional macro ICACHE_STATS_EN adds saturating hit_count / miss_count.
// Ports:
//   CLK, nRST            : clock, async active-low reset
//   imemREN, imemaddr    : fetch request and address ([1:0] ignored)
//   ihit, imemload       : fetch result (imemload is 0 when ihit=0)
//   iREN, iaddr          : memory read request and word-aligned address
//   iwait, iload         : memory busy and read data
//   hit_count, miss_count: statistics (ICACHE_STATS_EN only)
//
// state  | meaning
// IDLE   | serve hits; a miss latches the address and starts a refill
// REFILL | read memory for the latched address until iwait drops, then fill
module icache_direct_mapped
  import cpu_types_pkg::*;
#(
  parameter int unsigned NUM_SETS = ICACHE_SETS,
  parameter int unsigned WORD_W   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = WORD_W - 2 - IDX_W;

  icache_state_t     state_q, state_d;
  logic [WORD_W-1:2] miss_addr_q, miss_addr_d;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [WORD_W-1:0] rd_data;
  logic              hit;
  logic              miss_start;
  logic              fill;

  logic unused_byte_offset;
  assign unused_byte_offset = ^imemaddr[1:0];

  icache_frame_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .DATA_W   (WORD_W)
  ) u_frames (
    .CLK        (CLK),
    .nRST       (nRST),
    .rd_idx_i   (imemaddr[IDX_W+1:2]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (fill),
    .wr_idx_i   (miss_addr_q[IDX_W+1:2]),
    .wr_tag_i   (miss_addr_q[WORD_W-1:IDX_W+2]),
    .wr_data_i  (iload)
  );

  assign hit        = imemREN & rd_valid & (rd_tag == imemaddr[WORD_W-1:IDX_W+2]);
  assign miss_start = (state_q == IDLE) & imemREN & ~hit;
  assign fill       = (state_q == REFILL) & ~iwait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      IDLE: begin
        if (miss_start) begin
          state_d     = REFILL;
          miss_addr_d = imemaddr[WORD_W-1:2];
        end
      end
      REFILL: begin
        // Completes for the latched address even if the fetch redirects or halts.
        if (!iwait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          ihit     = 1'b1;
          imemload = rd_data;
        end
      end
      REFILL: begin
        iREN  = 1'b1;
        iaddr = {miss_addr_q, 2'b00};
      end
      default: ;
    endcase
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == IDLE) && hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 32'd1;
    if (miss_start && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed testbench for icache_direct_mapped. Inputs change 2 time units after
// the rising edge; outputs are sampled 1 unit later, away from either edge.
module tb_icache_direct_mapped;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        iwait = 1'b1;
  logic [31:0] iload = '0;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  icache_direct_mapped dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset();
    imemREN = 1'b1; imemaddr = 32'h40;
    #1 nRST = 1'b0;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit got=%0h exp=0", ihit); end
    checks++; if (imemload !== 32'h0) begin errors++; $display("FAIL reset_imemload got=%0h exp=0", imemload); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_iREN got=%0h exp=0", iREN); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr got=%0h exp=0", iaddr); end
    cyc();
    nRST = 1'b1; imemREN = 1'b0;
    cyc();
    #1;
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL idle_noren_iREN got=%0h exp=0", iREN); end
  endtask

  task automatic test_cold_miss();
    imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL cold_detect_ihit got=%0h exp=0", ihit); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL cold_detect_iREN got=%0h exp=0", iREN); end
    cyc();
    for (int i = 0; i < 4; i++) begin
      iwait = (i < 3);
      iload = (i == 3) ? 32'h2002_0005 : 32'hDEAD_BEEF;
      #1;
      checks++; if (iREN !== 1'b1) begin errors++; $display("FAIL cold_refill_iREN[%0d] got=%0h exp=1", i, iREN); end
      checks++; if (iaddr !== 32'h40) begin errors++; $display("FAIL cold_refill_iaddr[%0d] got=%0h exp=40", i, iaddr); end
      checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL cold_refill_ihit[%0d] got=%0h exp=0", i, ihit); end
      cyc();
    end
    iwait = 1'b1; iload = '0;
    #1;
    checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL cold_after_ihit got=%0h exp=1", ihit); end
    checks++; if (imemload !== 32'h2002_0005) begin errors++; $display("FAIL cold_after_data got=%0h exp=20020005", imemload); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL cold_after_iREN got=%0h exp=0", iREN); end
  endtask

  task automatic test_warm_hit();
    imemaddr = 32'h42;
    #1;
    checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL warm_42_ihit got=%0h exp=1", ihit); end
    checks++; if (imemload !== 32'h2002_0005) begin errors++; $display("FAIL warm_42_data got=%0h exp=20020005", imemload); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL warm_42_iREN got=%0h exp=0", iREN); end
    imemREN = 1'b0;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL warm_noren_ihit got=%0h exp=0", ihit); end
    checks++; if (imemload !== 32'h0) begin errors++; $display("FAIL warm_noren_data got=%0h exp=0", imemload); end
    cyc();
    imemREN = 1'b1; imemaddr = 32'h40;
    #1;
    checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL warm_40_ihit got=%0h exp=1", ihit); end
    checks++; if (imemload !== 32'h2002_0005) begin errors++; $display("FAIL warm_40_data got=%0h exp=20020005", imemload); end
  endtask

  task automatic test_conflict();
    imemaddr = 32'h80;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL conf_80_ihit got=%0h exp=0", ihit); end
    cyc();
    iwait = 1'b0; iload = 32'h0BAD_0080;
    #1;
    checks++; if (iaddr !== 32'h80) begin errors++; $display("FAIL conf_80_iaddr got=%0h exp=80", iaddr); end
    cyc();
    iwait = 1'b1;
    #1;
    checks++; if (imemload !== 32'h0BAD_0080) begin errors++; $display("FAIL conf_80_data got=%0h exp=bad0080", imemload); end
    imemaddr = 32'h40;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL conf_40_evicted got=%0h exp=0", ihit); end
    cyc();
    #1;
    checks++; if (iaddr !== 32'h40) begin errors++; $display("FAIL conf_40_iaddr got=%0h exp=40", iaddr); end
    iwait = 1'b0; iload = 32'h2002_0005;
    cyc();
    iwait = 1'b1;
    #1;
    checks++; if (imemload !== 32'h2002_0005) begin errors++; $display("FAIL conf_40_refill got=%0h exp=20020005", imemload); end
  endtask

  task automatic test_redirect();
    imemaddr = 32'h100;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL redir_detect_ihit got=%0h exp=0", ihit); end
    cyc();
    imemaddr = 32'h200;
    #1;
    checks++; if (iaddr !== 32'h100) begin errors++; $display("FAIL redir_wait0_iaddr got=%0h exp=100", iaddr); end
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL redir_wait0_ihit got=%0h exp=0", ihit); end
    cyc();
    #1;
    checks++; if (iaddr !== 32'h100) begin errors++; $display("FAIL redir_wait1_iaddr got=%0h exp=100", iaddr); end
    iwait = 1'b0; iload = 32'h1111_0100;
    #1;
    checks++; if (iaddr !== 32'h100) begin errors++; $display("FAIL redir_fill_iaddr got=%0h exp=100", iaddr); end
    cyc();
    iwait = 1'b1; imemaddr = 32'h100;
    #1;
    checks++; if (imemload !== 32'h1111_0100) begin errors++; $display("FAIL redir_100_cached got=%0h exp=11110100", imemload); end
    imemaddr = 32'h200;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL redir_200_miss got=%0h exp=0", ihit); end
    cyc();
    #1;
    checks++; if (iaddr !== 32'h200) begin errors++; $display("FAIL redir_200_iaddr got=%0h exp=200", iaddr); end
    iwait = 1'b0; iload = 32'h2222_0200;
    cyc();
    iwait = 1'b1;
    #1;
    checks++; if (imemload !== 32'h2222_0200) begin errors++; $display("FAIL redir_200_data got=%0h exp=22220200", imemload); end
  endtask

  task automatic test_halt();
    imemaddr = 32'h48;
    cyc();
    imemREN = 1'b0;
    cyc();
    iwait = 1'b0; iload = 32'h3333_0048;
    #1;
    checks++; if (iaddr !== 32'h48) begin errors++; $display("FAIL halt_iaddr got=%0h exp=48", iaddr); end
    cyc();
    iwait = 1'b1;
    cyc();
    #1;
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL halt_stays_idle got=%0h exp=0", iREN); end
    imemREN = 1'b1;
    #1;
    checks++; if (imemload !== 32'h3333_0048) begin errors++; $display("FAIL halt_frame_written got=%0h exp=33330048", imemload); end
  endtask

  task automatic test_reset_mid_refill();
    imemaddr = 32'h40;
    cyc();
    iwait = 1'b0; iload = 32'h2002_0005;
    cyc();
    iwait = 1'b1;
    #1;
    checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL rst_pre_40_ihit got=%0h exp=1", ihit); end
    imemaddr = 32'h300;
    cyc();
    #1;
    checks++; if (iaddr !== 32'h300) begin errors++; $display("FAIL rst_refill_iaddr got=%0h exp=300", iaddr); end
    nRST = 1'b0;
    #1;
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL rst_mid_iREN got=%0h exp=0", iREN); end
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rst_mid_ihit got=%0h exp=0", ihit); end
    cyc();
    nRST = 1'b1;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rst_300_miss got=%0h exp=0", ihit); end
    imemaddr = 32'h40;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL rst_40_miss got=%0h exp=0", ihit); end
    cyc();
    #1;
    checks++; if (iaddr !== 32'h40) begin errors++; $display("FAIL rst_40_iaddr got=%0h exp=40", iaddr); end
    iwait = 1'b0; iload = 32'h2002_0005;
    cyc();
    iwait = 1'b1;
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    imemREN = 1'b0;
    #1 nRST = 1'b0;
    #1;
    checks++; if (hit_count !== 32'd0) begin errors++; $display("FAIL stats_reset_hits got=%0d exp=0", hit_count); end
    checks++; if (miss_count !== 32'd0) begin errors++; $display("FAIL stats_reset_misses got=%0d exp=0", miss_count); end
    cyc();
    nRST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40;
    cyc();
    iwait = 1'b0; iload = 32'h2002_0005;
    cyc();
    iwait = 1'b1;
    cyc();
    cyc();
    cyc();
    imemaddr = 32'h80;
    cyc();
    #1;
    checks++; if (hit_count !== 32'd3) begin errors++; $display("FAIL stats_hits got=%0d exp=3", hit_count); end
    checks++; if (miss_count !== 32'd2) begin errors++; $display("FAIL stats_misses got=%0d exp=2", miss_count); end
    iwait = 1'b0;
    cyc();
    iwait = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_warm_hit();
    test_conflict();
    test_redirect();
    test_halt();
    test_reset_mid_refill();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
